// File: rtl/ahb_spi_bridge_slave_p_pkg.sv
// Shared definitions for the AHB-to-SPI bridge slave front end:
// AHB transfer/size codes and the slave FSM state encoding.
package ahb_spi_bridge_slave_p_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_CAP  = 3'd4,
        ST_RD_DONE = 3'd5,
        ST_ERR1    = 3'd6,
        ST_ERR2    = 3'd7
    } state_e;

endpackage

// File: rtl/ahb_spi_bridge_slave_p_if.sv
// AHB-Lite slave bus plus TX/RX FIFO handshake of the bridge front end.
interface ahb_spi_bridge_slave_p_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned CMD_W = 1 + ADDR_W + DATA_W;

    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADYIN;
    logic              HREADYOUT;
    logic              HRESP;
    logic [DATA_W-1:0] HRDATA;

    logic [CMD_W-1:0]  tx_data;
    logic              tx_wr_en;
    logic              tx_full;
    logic [DATA_W-1:0] rx_data;
    logic              rx_rd_en;
    logic              rx_empty;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
        output HREADYOUT, HRESP, HRDATA,
        output tx_data, tx_wr_en,
        input  tx_full,
        input  rx_data, rx_empty,
        output rx_rd_en
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
        input  HREADYOUT, HRESP, HRDATA,
        input  tx_data, tx_wr_en,
        output tx_full,
        output rx_data, rx_empty,
        input  rx_rd_en
    );

endinterface

// File: rtl/ahb_spi_lane_align.sv
// Combinational size/alignment check for an incoming address phase and
// byte-lane extraction of write data into the LSBs of the frame data field.
module ahb_spi_lane_align #(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned LANE_W = $clog2(DATA_W / 8)
) (
    input  logic [LANE_W-1:0] chk_lane_i,
    input  logic [2:0]        chk_size_i,
    output logic              err_o,
    input  logic [LANE_W-1:0] lane_i,
    input  logic [2:0]        size_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] data_o
);

    localparam int unsigned NBYTES = DATA_W / 8;

    logic [LANE_W-1:0] align_mask;
    logic [DATA_W-1:0] shifted;

    // Oversize transfers are errors; otherwise low address bits below the size must be zero.
    always_comb begin
        align_mask = '0;
        err_o      = 1'b0;
        if (32'(chk_size_i) > LANE_W) begin
            err_o = 1'b1;
        end else begin
            align_mask = LANE_W'((32'd1 << chk_size_i) - 32'd1);
            err_o      = |(chk_lane_i & align_mask);
        end
    end

    always_comb begin
        shifted = wdata_i >> {lane_i, 3'b000};
        data_o  = '0;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (b < (32'd1 << size_i)) begin
                data_o[8*b +: 8] = shifted[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/ahb_spi_bridge_slave_p.sv
// AHB-Lite slave front end of the AHB-to-SPI bridge: turns transfers into TX
// command frames and returns RX FIFO data for reads, with wait states and timeout.
module ahb_spi_bridge_slave_p #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic                      HCLK,
    input  logic                      rst_n,
    ahb_spi_bridge_slave_p_if.slave   bus
);

    import ahb_spi_bridge_slave_p_pkg::*;

    localparam int unsigned CMD_W    = 1 + ADDR_W + DATA_W;
    localparam int unsigned LANE_W   = $clog2(DATA_W / 8);
    localparam int unsigned TMR_W    = $clog2(RD_TIMEOUT + 1);
    localparam int unsigned RW_BIT   = CMD_W - 1;
    localparam int unsigned ADDR_LSB = DATA_W;
    localparam int unsigned DATA_LSB = 0;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RD_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;

    logic              hready_c;
    logic              hresp_c;
    logic              accept_c;
    logic              addr_err_c;
    state_e            launch_c;
    logic [CMD_W-1:0]  tx_data_c;
    logic              tx_wr_en_c;
    logic              rx_rd_en_c;
    logic [DATA_W-1:0] wdata_al_c;

    ahb_spi_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .chk_lane_i (bus.HADDR[LANE_W-1:0]),
        .chk_size_i (bus.HSIZE),
        .err_o      (addr_err_c),
        .lane_i     (addr_q[LANE_W-1:0]),
        .size_i     (size_q),
        .wdata_i    (bus.HWDATA),
        .data_o     (wdata_al_c)
    );

    // Data phase completes in these states; a write only once the TX FIFO has room.
    always_comb begin
        case (state_q)
            ST_IDLE, ST_RD_DONE, ST_ERR2: hready_c = 1'b1;
            ST_WR:                        hready_c = !bus.tx_full;
            default:                      hready_c = 1'b0;
        endcase
    end

    assign accept_c = bus.HSEL && bus.HREADYIN && hready_c &&
                      ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));
    assign launch_c = addr_err_c ? ST_ERR1 : (bus.HWRITE ? ST_WR : ST_RD_REQ);

    always_comb begin
        state_d    = state_q;
        timer_d    = '0;
        hrdata_d   = hrdata_q;
        hresp_c    = 1'b0;
        tx_data_c  = '0;
        tx_wr_en_c = 1'b0;
        rx_rd_en_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) state_d = launch_c;
            end
            ST_WR: begin
                tx_data_c[RW_BIT]                = 1'b1;
                tx_data_c[ADDR_LSB +: ADDR_W]    = addr_q;
                tx_data_c[DATA_LSB +: DATA_W]    = wdata_al_c;
                if (!bus.tx_full) begin
                    tx_wr_en_c = 1'b1;
                    state_d    = accept_c ? launch_c : ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                tx_data_c[ADDR_LSB +: ADDR_W] = addr_q;
                if (!bus.tx_full) begin
                    tx_wr_en_c = 1'b1;
                    state_d    = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                // A response arriving in the timeout cycle still wins.
                if (!bus.rx_empty) begin
                    rx_rd_en_c = 1'b1;
                    state_d    = ST_RD_CAP;
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_ERR1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RD_CAP: begin
                hrdata_d = bus.rx_data;
                state_d  = ST_RD_DONE;
            end
            ST_RD_DONE: begin
                state_d = accept_c ? launch_c : ST_IDLE;
            end
            ST_ERR1: begin
                hresp_c = 1'b1;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_c = 1'b1;
                state_d = accept_c ? launch_c : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            hrdata_q <= hrdata_d;
        end
    end

    // Address-phase capture.
    always_ff @(posedge HCLK or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else if (accept_c) begin
            addr_q  <= bus.HADDR;
            write_q <= bus.HWRITE;
            size_q  <= bus.HSIZE;
        end
    end

    assign bus.HREADYOUT = hready_c;
    assign bus.HRESP     = hresp_c;
    assign bus.HRDATA    = hrdata_q;
    assign bus.tx_data   = tx_data_c;
    assign bus.tx_wr_en  = tx_wr_en_c && (write_q || (state_q == ST_RD_REQ));
    assign bus.rx_rd_en  = rx_rd_en_c;

endmodule

// File: tb/tb_ahb_spi_bridge_slave_p.sv
// Directed self-checking bench for ahb_spi_bridge_slave_p (ADDR_W=8, DATA_W=32, RD_TIMEOUT=8).
module tb_ahb_spi_bridge_slave_p;

    import ahb_spi_bridge_slave_p_pkg::*;

    logic HCLK = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 HCLK = ~HCLK;

    ahb_spi_bridge_slave_p_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    assign bus.HREADYIN = bus.HREADYOUT;

    ahb_spi_bridge_slave_p #(
        .ADDR_W     (8),
        .DATA_W     (32),
        .RD_TIMEOUT (8)
    ) dut (
        .HCLK  (HCLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic next_cycle();
        @(posedge HCLK);
        #2;
    endtask

    task automatic addr_phase(input logic wr, input logic [2:0] size, input logic [7:0] addr);
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        bus.HADDR  = addr;
    endtask

    task automatic bus_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_idle();
        bus.HSIZE = HSIZE_WORD; bus.HADDR = 8'h00; bus.HWDATA = 32'h0;
        bus.tx_full = 1'b0; bus.rx_empty = 1'b1; bus.rx_data = 32'h0;
        #1;
        n_checks++;
        if ({bus.HREADYOUT, bus.HRESP, bus.tx_wr_en, bus.rx_rd_en} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 1000", {bus.HREADYOUT, bus.HRESP, bus.tx_wr_en, bus.rx_rd_en});
        end
        n_checks++;
        if (bus.HRDATA !== 32'h0 || bus.tx_data !== 41'h0) begin
            n_fail++; $display("FAIL reset_data: HRDATA %h tx_data %h expected 0/0", bus.HRDATA, bus.tx_data);
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_word_write();
        logic [40:0] exp = {1'b1, 8'h14, 32'hDEADBEEF};
        next_cycle();
        addr_phase(1'b1, HSIZE_WORD, 8'h14);
        next_cycle();
        bus_idle();
        bus.HWDATA = 32'hDEADBEEF;
        #1;
        n_checks++;
        if ({bus.HREADYOUT, bus.HRESP, bus.tx_wr_en} !== 3'b101) begin
            n_fail++; $display("FAIL word_write_resp: got %b expected 101", {bus.HREADYOUT, bus.HRESP, bus.tx_wr_en});
        end
        n_checks++;
        if (bus.tx_data !== exp) begin
            n_fail++; $display("FAIL word_write_frame: got %h expected %h", bus.tx_data, exp);
        end
        next_cycle();
        n_checks++;
        if ({bus.HREADYOUT, bus.tx_wr_en} !== 2'b10) begin
            n_fail++; $display("FAIL word_write_single_pulse: got %b expected 10", {bus.HREADYOUT, bus.tx_wr_en});
        end
    endtask

    task automatic test_lanes_and_errors();
        logic [40:0] exp_b = {1'b1, 8'h23, 32'h000000AA};
        logic [40:0] exp_h = {1'b1, 8'h22, 32'h0000AABB};
        addr_phase(1'b1, HSIZE_BYTE, 8'h23);
        next_cycle();
        addr_phase(1'b1, HSIZE_HALF, 8'h22);
        bus.HWDATA = 32'hAABBCCDD;
        #1;
        n_checks++;
        if (bus.tx_wr_en !== 1'b1 || bus.tx_data !== exp_b) begin
            n_fail++; $display("FAIL byte_lane: wr_en %b tx_data %h expected 1 %h", bus.tx_wr_en, bus.tx_data, exp_b);
        end
        next_cycle();
        addr_phase(1'b1, HSIZE_HALF, 8'h21);
        bus.HWDATA = 32'hAABBCCDD;
        #1;
        n_checks++;
        if (bus.tx_wr_en !== 1'b1 || bus.tx_data !== exp_h) begin
            n_fail++; $display("FAIL half_lane: wr_en %b tx_data %h expected 1 %h", bus.tx_wr_en, bus.tx_data, exp_h);
        end
        next_cycle();
        bus_idle();
        #1;
        n_checks++;
        if ({bus.HREADYOUT, bus.HRESP, bus.tx_wr_en} !== 3'b010) begin
            n_fail++; $display("FAIL misalign_err1: got %b expected 010", {bus.HREADYOUT, bus.HRESP, bus.tx_wr_en});
        end
        next_cycle();
        #1;
        n_checks++;
        if ({bus.HREADYOUT, bus.HRESP, bus.tx_wr_en} !== 3'b110) begin
            n_fail++; $display("FAIL misalign_err2: got %b expected 110", {bus.HREADYOUT, bus.HRESP, bus.tx_wr_en});
        end
        next_cycle();
        n_checks++;
        if ({bus.HREADYOUT, bus.HRESP, bus.tx_wr_en} !== 3'b100) begin
            n_fail++; $display("FAIL misalign_idle: got %b expected 100", {bus.HREADYOUT, bus.HRESP, bus.tx_wr_en});
        end
        addr_phase(1'b0, HSIZE_DWORD, 8'h00);
        next_cycle();
        bus_idle();
        #1;
        n_checks++;
        if ({bus.HREADYOUT, bus.HRESP, bus.tx_wr_en} !== 3'b010) begin
            n_fail++; $display("FAIL oversize_err1: got %b expected 010", {bus.HREADYOUT, bus.HRESP, bus.tx_wr_en});
        end
        next_cycle();
        next_cycle();
    endtask

    task automatic test_word_read();
        logic [40:0] exp = {1'b0, 8'h40, 32'h0};
        int pops = 0;
        addr_phase(1'b0, HSIZE_WORD, 8'h40);
        bus.rx_empty = 1'b0;
        bus.rx_data  = 32'hBAD0BAD0;
        next_cycle();
        bus_idle();
        #1;
        pops += int'(bus.rx_rd_en);
        n_checks++;
        if (bus.tx_wr_en !== 1'b1 || bus.tx_data !== exp || bus.HREADYOUT !== 1'b0) begin
            n_fail++; $display("FAIL read_req: wr_en %b tx_data %h hready %b expected 1 %h 0", bus.tx_wr_en, bus.tx_data, bus.HREADYOUT, exp);
        end
        next_cycle();
        #1;
        pops += int'(bus.rx_rd_en);
        n_checks++;
        if ({bus.HREADYOUT, bus.tx_wr_en, bus.rx_rd_en} !== 3'b001) begin
            n_fail++; $display("FAIL read_pop: got %b expected 001", {bus.HREADYOUT, bus.tx_wr_en, bus.rx_rd_en});
        end
        next_cycle();
        bus.rx_data = 32'h12345678;
        #1;
        pops += int'(bus.rx_rd_en);
        next_cycle();
        bus.rx_data  = 32'hBAD0BAD0;
        bus.rx_empty = 1'b1;
        #1;
        pops += int'(bus.rx_rd_en);
        n_checks++;
        if (bus.HRDATA !== 32'h12345678 || {bus.HREADYOUT, bus.HRESP} !== 2'b10) begin
            n_fail++; $display("FAIL read_done: HRDATA %h resp %b expected 12345678 10", bus.HRDATA, {bus.HREADYOUT, bus.HRESP});
        end
        n_checks++;
        if (pops != 1) begin
            n_fail++; $display("FAIL read_pop_count: got %0d expected 1", pops);
        end
        next_cycle();
    endtask

    task automatic test_tx_full_stall();
        logic [40:0] exp = {1'b1, 8'h08, 32'h01020304};
        int stall_bad = 0;
        addr_phase(1'b1, HSIZE_WORD, 8'h08);
        next_cycle();
        bus_idle();
        bus.HWDATA  = 32'h01020304;
        bus.tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.HREADYOUT !== 1'b0 || bus.tx_wr_en !== 1'b0) stall_bad++;
            if (i < 4) next_cycle();
        end
        n_checks++;
        if (stall_bad != 0) begin
            n_fail++; $display("FAIL stall_hold: got %0d bad stall cycles expected 0", stall_bad);
        end
        next_cycle();
        bus.tx_full = 1'b0;
        #1;
        n_checks++;
        if ({bus.HREADYOUT, bus.HRESP, bus.tx_wr_en} !== 3'b101 || bus.tx_data !== exp) begin
            n_fail++; $display("FAIL stall_release: resp %b tx_data %h expected 101 %h", {bus.HREADYOUT, bus.HRESP, bus.tx_wr_en}, bus.tx_data, exp);
        end
        next_cycle();
    endtask

    task automatic test_read_timeout();
        int wait_bad = 0;
        addr_phase(1'b0, HSIZE_WORD, 8'h44);
        bus.rx_empty = 1'b1;
        next_cycle();
        bus_idle();
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            #1;
            if ({bus.HREADYOUT, bus.HRESP, bus.rx_rd_en} !== 3'b000) wait_bad++;
        end
        n_checks++;
        if (wait_bad != 0) begin
            n_fail++; $display("FAIL timeout_wait: got %0d bad wait cycles expected 0", wait_bad);
        end
        next_cycle();
        #1;
        n_checks++;
        if ({bus.HREADYOUT, bus.HRESP, bus.rx_rd_en} !== 3'b010) begin
            n_fail++; $display("FAIL timeout_err1: got %b expected 010", {bus.HREADYOUT, bus.HRESP, bus.rx_rd_en});
        end
        next_cycle();
        #1;
        n_checks++;
        if ({bus.HREADYOUT, bus.HRESP} !== 2'b11 || bus.HRDATA !== 32'h12345678) begin
            n_fail++; $display("FAIL timeout_err2: resp %b HRDATA %h expected 11 12345678", {bus.HREADYOUT, bus.HRESP}, bus.HRDATA);
        end
        next_cycle();
    endtask

    task automatic test_timeout_race();
        addr_phase(1'b0, HSIZE_WORD, 8'h48);
        bus.rx_empty = 1'b1;
        next_cycle();
        bus_idle();
        for (int i = 0; i < 7; i++) next_cycle();
        next_cycle();
        bus.rx_empty = 1'b0;
        #1;
        n_checks++;
        if ({bus.HREADYOUT, bus.HRESP, bus.rx_rd_en} !== 3'b001) begin
            n_fail++; $display("FAIL race_pop: got %b expected 001", {bus.HREADYOUT, bus.HRESP, bus.rx_rd_en});
        end
        next_cycle();
        bus.rx_empty = 1'b1;
        bus.rx_data  = 32'hCAFEF00D;
        next_cycle();
        #1;
        n_checks++;
        if (bus.HRDATA !== 32'hCAFEF00D || {bus.HREADYOUT, bus.HRESP} !== 2'b10) begin
            n_fail++; $display("FAIL race_done: HRDATA %h resp %b expected cafef00d 10", bus.HRDATA, {bus.HREADYOUT, bus.HRESP});
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [40:0] exp_w = {1'b1, 8'h10, 32'h55AA55AA};
        logic [40:0] exp_r = {1'b0, 8'h30, 32'h0};
        int late = 0;
        addr_phase(1'b1, HSIZE_WORD, 8'h10);
        next_cycle();
        addr_phase(1'b0, HSIZE_WORD, 8'h30);
        bus.HWDATA = 32'h55AA55AA;
        #1;
        n_checks++;
        if (bus.tx_wr_en !== 1'b1 || bus.HREADYOUT !== 1'b1 || bus.tx_data !== exp_w) begin
            n_fail++; $display("FAIL b2b_write: wr_en %b hready %b tx_data %h expected 1 1 %h", bus.tx_wr_en, bus.HREADYOUT, bus.tx_data, exp_w);
        end
        next_cycle();
        bus_idle();
        #1;
        n_checks++;
        if (bus.tx_wr_en !== 1'b1 || bus.HREADYOUT !== 1'b0 || bus.tx_data !== exp_r) begin
            n_fail++; $display("FAIL b2b_read_no_bubble: wr_en %b hready %b tx_data %h expected 1 0 %h", bus.tx_wr_en, bus.HREADYOUT, bus.tx_data, exp_r);
        end
        next_cycle();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.HREADYOUT, bus.HRESP, bus.tx_wr_en, bus.rx_rd_en} !== 4'b1000 || bus.HRDATA !== 32'h0 || bus.tx_data !== 41'h0) begin
            n_fail++; $display("FAIL midreset_values: ctrl %b HRDATA %h tx_data %h expected 1000 0 0", {bus.HREADYOUT, bus.HRESP, bus.tx_wr_en, bus.rx_rd_en}, bus.HRDATA, bus.tx_data);
        end
        bus.rx_empty = 1'b0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            if (i == 1) rst_n = 1'b1;
            #1;
            if (bus.rx_rd_en !== 1'b0 || bus.tx_wr_en !== 1'b0) late++;
        end
        n_checks++;
        if (late != 0) begin
            n_fail++; $display("FAIL midreset_no_late_pop: got %0d active cycles expected 0", late);
        end
        bus.rx_empty = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_write();
        test_lanes_and_errors();
        test_word_read();
        test_tx_full_stall();
        test_read_timeout();
        test_timeout_race();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
